// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
// Queue entries carry the destination, the pair-write flag and the full 56-bit result.
package rf_pkg;

    localparam int NREG      = 16;
    localparam int RF_HALF_W = 28;
    localparam int RF_W      = 56;
    localparam int CNT_W     = 3;

    typedef struct packed {
        logic [3:0]      dest;
        logic            simd;
        logic [RF_W-1:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    // True when entry e will write register r. A pair write to r15 cannot
    // wrap, so it only covers r15 itself.
    function automatic logic covers(input wb_entry_t e, input logic [3:0] r);
        logic pair_ok;
        pair_ok = e.simd && (e.dest != 4'hF);
        return (e.dest == r) || (pair_ok && ((e.dest + 4'd1) == r));
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback queue: count-based FIFO of DEPTH entries.
// Latency: an entry pushed at edge N is visible at the head after edge N.
// Backpressure: full is a function of the count only; push must not be asserted while full.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 61
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);

endmodule

// File: rtl/rf_writeback.sv
// Merges ALU (s0) and load (s1) results into the single register-file write port, round-robin.
// Latency: 1 cycle from accept to registered write when both queues are empty and hold is low.
// Backpressure: sk_ready is queue-not-full; hold stalls issue while accepts continue until full.
module rf_writeback #(
    parameter int DEPTH = 2,
    parameter int NREG  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  logic [3:0]      s0_dest,
    input  logic            s0_simd,
    input  logic [55:0]     s0_data,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [3:0]      s1_dest,
    input  logic            s1_simd,
    input  logic [55:0]     s1_data,
    input  logic            hold,
    output logic            wen,
    output logic [3:0]      dest_sel,
    output logic            iswrSIMD,
    output logic [55:0]     data_in,
    output logic [NREG-1:0] pending,
    output logic            err_simd_wrap
);

    import rf_pkg::*;

    wb_entry_t in0, in1, head0, head1, head;
    logic      full0, full1, empty0, empty1;
    logic      acc0, acc1, issue, grant1, pop0, pop1, pair_ok;

    logic            wen_q, wen_d;
    logic [3:0]      dest_sel_q, dest_sel_d;
    logic            simd_q, simd_d;
    logic [RF_W-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic            rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    assign in0 = '{dest: s0_dest, simd: s0_simd, data: s0_data};
    assign in1 = '{dest: s1_dest, simd: s1_simd, data: s1_data};

    wb_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_q0 (
        .clk(clk), .rst(rst), .push(acc0), .push_dat(in0), .pop(pop0),
        .pop_dat(head0), .full(full0), .empty(empty0)
    );

    wb_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_q1 (
        .clk(clk), .rst(rst), .push(acc1), .push_dat(in1), .pop(pop1),
        .pop_dat(head1), .full(full1), .empty(empty1)
    );

    assign s0_ready = ~full0;
    assign s1_ready = ~full1;
    assign acc0     = s0_valid & ~full0;
    assign acc1     = s1_valid & ~full1;

    // rr_q set means s1 holds priority when both heads are waiting.
    assign issue   = ~hold & (~empty0 | ~empty1);
    assign grant1  = ~empty1 & (empty0 | rr_q);
    assign pop0    = issue & ~grant1;
    assign pop1    = issue & grant1;
    assign head    = grant1 ? head1 : head0;
    assign pair_ok = head.simd && (head.dest != 4'hF);

    always_comb begin
        wen_d      = 1'b0;
        dest_sel_d = dest_sel_q;
        simd_d     = simd_q;
        data_d     = data_q;
        err_d      = err_q;
        rr_d       = rr_q;
        if (issue) begin
            wen_d      = 1'b1;
            dest_sel_d = head.dest;
            simd_d     = pair_ok;
            data_d     = pair_ok ? head.data
                                 : {head.data[RF_W-1:RF_HALF_W], {RF_HALF_W{1'b0}}};
            rr_d       = ~grant1;
            if (head.simd && (head.dest == 4'hF)) begin
                err_d = 1'b1;
            end
        end
    end

    // Both accepts and the issue can touch one register in the same cycle.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i]
                     + CNT_W'(acc0 && covers(in0, 4'(i)))
                     + CNT_W'(acc1 && covers(in1, 4'(i)))
                     - CNT_W'(issue && covers(head, 4'(i)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q      <= 1'b0;
            dest_sel_q <= '0;
            simd_q     <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            rr_q       <= 1'b0;
            cnt_q      <= '{default: '0};
        end else begin
            wen_q      <= wen_d;
            dest_sel_q <= dest_sel_d;
            simd_q     <= simd_d;
            data_q     <= data_d;
            err_q      <= err_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NREG; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    assign wen           = wen_q;
    assign dest_sel      = dest_sel_q;
    assign iswrSIMD      = simd_q;
    assign data_in       = data_q;
    assign err_simd_wrap = err_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: a cycle-by-cycle vector table plus hand-written
// sequences for hold back-pressure and mid-operation reset.
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_ready, s0_simd;
    logic [3:0]  s0_dest;
    logic [55:0] s0_data;
    logic        s1_valid, s1_ready, s1_simd;
    logic [3:0]  s1_dest;
    logic [55:0] s1_data;
    logic        hold;
    logic        wen, iswrSIMD, err_simd_wrap;
    logic [3:0]  dest_sel;
    logic [55:0] data_in;
    logic [15:0] pending;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic        s0v;
        logic [3:0]  s0d;
        logic        s0s;
        logic [55:0] s0x;
        logic        s1v;
        logic [3:0]  s1d;
        logic        s1s;
        logic [55:0] s1x;
        logic        hld;
        logic        e_wen;
        logic [3:0]  e_dest;
        logic        e_simd;
        logic [55:0] e_data;
        logic [15:0] e_pend;
        logic        e_r0;
        logic        e_r1;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    rf_writeback #(.DEPTH(2), .NREG(16)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_dest(s0_dest), .s0_simd(s0_simd), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_dest(s1_dest), .s1_simd(s1_simd), .s1_data(s1_data),
        .hold(hold), .wen(wen), .dest_sel(dest_sel), .iswrSIMD(iswrSIMD), .data_in(data_in),
        .pending(pending), .err_simd_wrap(err_simd_wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic s0v, input logic [3:0] s0d, input logic s0s, input logic [55:0] s0x,
                       input logic s1v, input logic [3:0] s1d, input logic s1s, input logic [55:0] s1x,
                       input logic hld, input logic e_wen, input logic [3:0] e_dest, input logic e_simd,
                       input logic [55:0] e_data, input logic [15:0] e_pend, input logic e_r0,
                       input logic e_r1, input logic e_err);
        vec_t v;
        v = '{s0v, s0d, s0s, s0x, s1v, s1d, s1s, s1x, hld, e_wen, e_dest, e_simd, e_data, e_pend, e_r0, e_r1, e_err};
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        s0_valid = 0; s0_dest = 0; s0_simd = 0; s0_data = '0;
        s1_valid = 0; s1_dest = 0; s1_simd = 0; s1_data = '0;
        hold = 0;
    endtask

    task automatic chk_port(input string nm, input logic e_wen, input logic [3:0] e_dest,
                            input logic [55:0] e_data);
        chk({nm, "_wen"}, 64'(wen), 64'(e_wen));
        chk({nm, "_dest"}, 64'(dest_sel), 64'(e_dest));
        chk({nm, "_data"}, 64'(data_in), 64'(e_data));
    endtask

    initial begin
        localparam logic [55:0] Z = 56'h0;
        idle_inputs();
        rst = 1;

        // Scalar, pair, and pair-at-r15 writes.
        add(1, 3, 0, 56'hABCDEF1_1234567, 0, 0, 0, Z, 0, 0, 0, 0, Z, 16'h0008, 1, 1, 0);
        add(0, 0, 0, Z, 0, 0, 0, Z, 0, 1, 3, 0, 56'hABCDEF1_0000000, 16'h0000, 1, 1, 0);
        add(0, 0, 0, Z, 0, 0, 0, Z, 0, 0, 3, 0, 56'hABCDEF1_0000000, 16'h0000, 1, 1, 0);
        add(0, 0, 0, Z, 1, 7, 1, 56'h1111111_2222222, 0, 0, 3, 0, 56'hABCDEF1_0000000, 16'h0180, 1, 1, 0);
        add(0, 0, 0, Z, 0, 0, 0, Z, 0, 1, 7, 1, 56'h1111111_2222222, 16'h0000, 1, 1, 0);
        add(0, 0, 0, Z, 1, 15, 1, 56'h3333333_4444444, 0, 0, 7, 1, 56'h1111111_2222222, 16'h8000, 1, 1, 0);
        add(0, 0, 0, Z, 0, 0, 0, Z, 0, 1, 15, 0, 56'h3333333_0000000, 16'h0000, 1, 1, 1);
        add(0, 0, 0, Z, 0, 0, 0, Z, 0, 0, 15, 0, 56'h3333333_0000000, 16'h0000, 1, 1, 1);
        // Both sources streaming: grants alternate, readiness toggles.
        add(1, 1, 0, 56'h1000000_FFFFFFF, 1, 2, 0, 56'h2000000_FFFFFFF, 0, 0, 15, 0, 56'h3333333_0000000, 16'h0006, 1, 1, 1);
        add(1, 1, 0, 56'h1000001_FFFFFFF, 1, 2, 0, 56'h2000001_FFFFFFF, 0, 1, 1, 0, 56'h1000000_0000000, 16'h0006, 1, 0, 1);
        add(1, 1, 0, 56'h1000002_FFFFFFF, 1, 2, 0, 56'h2000002_FFFFFFF, 0, 1, 2, 0, 56'h2000000_0000000, 16'h0006, 0, 1, 1);
        add(1, 1, 0, 56'h1000003_FFFFFFF, 1, 2, 0, 56'h2000003_FFFFFFF, 0, 1, 1, 0, 56'h1000001_0000000, 16'h0006, 1, 0, 1);
        add(1, 1, 0, 56'h1000004_FFFFFFF, 1, 2, 0, 56'h2000004_FFFFFFF, 0, 1, 2, 0, 56'h2000001_0000000, 16'h0006, 0, 1, 1);
        add(1, 1, 0, 56'h1000005_FFFFFFF, 1, 2, 0, 56'h2000005_FFFFFFF, 0, 1, 1, 0, 56'h1000002_0000000, 16'h0006, 1, 0, 1);
        add(1, 1, 0, 56'h1000006_FFFFFFF, 1, 2, 0, 56'h2000006_FFFFFFF, 0, 1, 2, 0, 56'h2000003_0000000, 16'h0006, 0, 1, 1);
        add(1, 1, 0, 56'h1000007_FFFFFFF, 1, 2, 0, 56'h2000007_FFFFFFF, 0, 1, 1, 0, 56'h1000004_0000000, 16'h0006, 1, 0, 1);
        add(0, 0, 0, Z, 0, 0, 0, Z, 0, 1, 2, 0, 56'h2000005_0000000, 16'h0006, 1, 1, 1);
        add(0, 0, 0, Z, 0, 0, 0, Z, 0, 1, 1, 0, 56'h1000006_0000000, 16'h0004, 1, 1, 1);
        add(0, 0, 0, Z, 0, 0, 0, Z, 0, 1, 2, 0, 56'h2000007_0000000, 16'h0000, 1, 1, 1);
        add(0, 0, 0, Z, 0, 0, 0, Z, 0, 0, 2, 0, 56'h2000007_0000000, 16'h0000, 1, 1, 1);

        // Reset state.
        tick();
        tick();
        chk_port("rst", 0, 0, Z);
        chk("rst_simd", 64'(iswrSIMD), 64'(0));
        chk("rst_pend", 64'(pending), 64'(0));
        chk("rst_err", 64'(err_simd_wrap), 64'(0));
        chk("rst_rdy", 64'({s0_ready, s1_ready}), 64'(2'b11));
        rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            s0_valid = vecs[i].s0v; s0_dest = vecs[i].s0d; s0_simd = vecs[i].s0s; s0_data = vecs[i].s0x;
            s1_valid = vecs[i].s1v; s1_dest = vecs[i].s1d; s1_simd = vecs[i].s1s; s1_data = vecs[i].s1x;
            hold = vecs[i].hld;
            tick();
            chk_port($sformatf("v%0d", i), vecs[i].e_wen, vecs[i].e_dest, vecs[i].e_data);
            chk($sformatf("v%0d_simd", i), 64'(iswrSIMD), 64'(vecs[i].e_simd));
            chk($sformatf("v%0d_pend", i), 64'(pending), 64'(vecs[i].e_pend));
            chk($sformatf("v%0d_rdy", i), 64'({s0_ready, s1_ready}), 64'({vecs[i].e_r0, vecs[i].e_r1}));
            chk($sformatf("v%0d_err", i), 64'(err_simd_wrap), 64'(vecs[i].e_err));
        end

        // Hold with both sources pushing: two entries per queue, then stalled.
        for (int j = 0; j < 6; j++) begin
            s0_valid = 1; s0_dest = 4; s0_simd = 0; s0_data = {28'h4000000 + 28'(j), 28'h5555555};
            s1_valid = 1; s1_dest = 5; s1_simd = 0; s1_data = {28'h5000000 + 28'(j), 28'h5555555};
            hold = 1;
            tick();
            chk($sformatf("hold%0d_wen", j), 64'(wen), 64'(0));
        end
        chk("hold_rdy", 64'({s0_ready, s1_ready}), 64'(2'b00));
        chk("hold_pend", 64'(pending), 64'(16'h0030));
        idle_inputs();
        tick();
        chk_port("drain0", 1, 4, 56'h4000000_0000000);
        tick();
        chk_port("drain1", 1, 5, 56'h5000000_0000000);
        tick();
        chk_port("drain2", 1, 4, 56'h4000001_0000000);
        tick();
        chk_port("drain3", 1, 5, 56'h5000001_0000000);
        chk("drain3_pend", 64'(pending), 64'(0));
        tick();
        chk("drain4_wen", 64'(wen), 64'(0));
        chk("drain4_err", 64'(err_simd_wrap), 64'(1));

        // Three entries queued, one issuing, then asynchronous reset mid-cycle.
        s0_valid = 1; s0_dest = 9; s1_valid = 1; s1_dest = 10; hold = 1;
        tick();
        s1_valid = 0;
        tick();
        idle_inputs();
        tick();
        chk_port("pre_rst", 1, 9, Z);
        chk("pre_rst_pend", 64'(pending), 64'(16'h0600));
        #2 rst = 1;
        #1;
        chk_port("mid_rst", 0, 0, Z);
        chk("mid_rst_pend", 64'(pending), 64'(0));
        chk("mid_rst_err", 64'(err_simd_wrap), 64'(0));
        chk("mid_rst_rdy", 64'({s0_ready, s1_ready}), 64'(2'b11));
        tick();
        tick();
        rst = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("post_rst%0d_wen", j), 64'(wen), 64'(0));
        end
        s0_valid = 1; s0_dest = 6; s0_data = 56'h7654321_ABCDEF0;
        tick();
        idle_inputs();
        chk("new_acc_pend", 64'(pending), 64'(16'h0040));
        tick();
        chk_port("new_acc", 1, 6, 56'h7654321_0000000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, the per-source queue depth in entries.
REQ-002 SHALL have parameter NREG, default 16, the number of registers in the register file.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s0_valid/s1_valid  in  1  result offered by ALU (s0) / load unit (s1).
REQ-006 SHALL have ports s0_ready/s1_ready  out  1  the source queue can accept an entry.
REQ-007 SHALL have ports s0_dest/s1_dest  in  4  destination register.
REQ-008 SHALL have ports s0_simd/s1_simd  in  1  pair write to dest and dest+1.
REQ-009 SHALL have ports s0_data/s1_data  in  56  result; the scalar payload is in [55:28].
REQ-010 SHALL have port hold  in  1  suppress issue this cycle.
REQ-011 SHALL have port wen  out  1  register file write enable.
REQ-012 SHALL have port dest_sel  out  4  register file write address.
REQ-013 SHALL have port iswrSIMD  out  1  register file pair write.
REQ-014 SHALL have port data_in  out  56  register file write data.
REQ-015 SHALL have port pending  out  16  per-register "write queued, not yet issued" mask.
REQ-016 SHALL have port err_simd_wrap  out  1  sticky flag: a SIMD write to register 15 was seen.

Function
REQ-017 Accept: an entry SHALL be enqueued into source queue k on a posedge where sk_valid && sk_ready; queues are FIFO, DEPTH entries each.
REQ-018 sk_ready SHALL be 1 iff queue k is not full; it SHALL be a registered or count-derived signal that does not depend on sk_valid.
REQ-019 Issue: on each posedge with hold=0 and at least one queue non-empty, exactly one head entry SHALL be dequeued and driven on wen/dest_sel/iswrSIMD/data_in.
REQ-020 The write-port outputs SHALL be registered, stable for one full cycle, so the register file captures them on the intervening negedge.
REQ-021 On a posedge with no issue, wen SHALL be 0; dest_sel/iswrSIMD/data_in SHALL hold their previous values.
REQ-022 Arbitration SHALL be round-robin: when both queues are non-empty, the source not granted last wins; after reset s0 has priority.
REQ-023 Minimum latency SHALL be 1 cycle: an entry accepted at posedge N with both queues empty and hold=0 SHALL appear with wen=1 from posedge N+1.
REQ-024 Writes from the same source SHALL issue in acceptance order; no ordering SHALL be guaranteed between sources.
REQ-025 SIMD with dest<=14 SHALL issue as iswrSIMD=1, dest_sel=dest, data_in=data.
REQ-026 SIMD with dest=15 SHALL issue as a scalar write (iswrSIMD=0, dest_sel=15, data_in[55:28]=data[55:28]) and SHALL set err_simd_wrap.
REQ-027 Scalar entries SHALL issue with iswrSIMD=0 and data_in={data[55:28],28'b0}.
REQ-028 Pending: the block SHALL keep a 3-bit counter per register, incremented on accept and decremented on issue for each register the entry covers (dest, plus dest+1 for SIMD with dest<=14).
REQ-029 Simultaneous accepts from both sources plus an issue touching the same register SHALL net-sum into that register's counter in one cycle.
REQ-030 pending[i] SHALL equal (count[i]!=0), reflecting state after the current posedge.
REQ-031 When hold=1, no dequeue SHALL occur; accepts SHALL continue until the queues are full.

Reset
REQ-032 While rst=1: queues SHALL be empty, s0_ready=s1_ready=1, wen=0, dest_sel=0, iswrSIMD=0, data_in=0, pending=0, err_simd_wrap=0, round-robin pointer=s0.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries with no further write issued; err_simd_wrap SHALL clear only on reset.

Structure
REQ-034 Shared package rf_pkg SHALL hold NREG, RF_HALF_W=28, RF_W=56 and the queue-entry struct {dest[3:0], simd, data[55:0]}.
REQ-035 The per-source queue SHALL be one sub-module, wb_fifo (parameterised DEPTH, entry width), instantiated twice.

Verification
REQ-036 Scalar s0 dest=3, data upper=0xABCDEF1 at N -> at N+1 wen=1, dest_sel=3, iswrSIMD=0, data_in=0xABCDEF1_0000000; pending[3] is 1 after N and 0 after N+1.
REQ-037 Both sources valid every cycle for 8 cycles (dest s0=1, s1=2) -> grants alternate s0,s1,s0,...; neither ready stays 0 for more than 1 cycle.
REQ-038 hold=1 for 6 cycles with both sources pushing -> exactly 2 entries accepted per source, then s0_ready=s1_ready=0, wen=0; hold drops -> 4 writes on 4 consecutive cycles in FIFO/RR order.
REQ-039 SIMD s1 dest=15 -> scalar write to 15 with upper half only, err_simd_wrap=1 and sticky; SIMD dest=7 -> iswrSIMD=1, pending[7] and pending[8] both set then both cleared.
REQ-040 rst asserted with 3 entries queued -> wen=0 immediately, pending=0, no writes after rst deasserts until new accepts.
